// File: rtl/fmul_round_pack_pkg.sv
// Shared FP32 constants, classification enum and unpacked-operand struct for the
// multiplier back end (round/pack stage).
package fpu_pkg;

    localparam logic [7:0]  EXP_MAX   = 8'hff;
    localparam int          EXP_BIAS  = 127;
    localparam logic [22:0] QNAN_MANT = 23'h400000;

    typedef enum logic [1:0] {
        FP_NORMAL,
        FP_ZERO,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] frac;
    } fp_unpacked_t;

    // Error beats overflow beats exponent-all-ones beats zero.
    function automatic fp_class_t classify(input logic err, input logic ovf, input logic [7:0] exp);
        if (err)
            return FP_NAN;
        if (ovf || exp == EXP_MAX)
            return FP_INF;
        if (exp == 8'd0)
            return FP_ZERO;
        return FP_NORMAL;
    endfunction

endpackage

// File: rtl/fmul_round_pack_if.sv
// Handshake bus between the FP32 multiplier core (master) and the round/pack
// stage (slave), covering both the unpacked input side and the packed output side.
interface fmul_round_pack_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [23:0] in_frac;
    logic        in_error;
    logic        in_overflow;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_invalid;
    logic        out_ovf;
    logic        out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
        input  in_ready, out_valid, out_result, out_invalid, out_ovf, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
        output in_ready, out_valid, out_result, out_invalid, out_ovf, out_inexact
    );

endinterface

// File: rtl/fmul_round_pack_round_inc.sv
// Mantissa round increment with carry into the exponent; flags the case where the
// carry pushes the exponent to all-ones, which saturates the result to infinity.
module fp_round_inc
    import fpu_pkg::*;
(
    input  logic [7:0]  i_exp,
    input  logic [22:0] i_mant,
    input  logic        i_inc,
    output logic [7:0]  o_exp,
    output logic [22:0] o_mant,
    output logic        o_ovf
);

    logic        w_carry;
    logic [22:0] w_sum;
    logic [7:0]  w_exp_inc;

    assign {w_carry, w_sum} = {1'b0, i_mant} + {23'd0, i_inc};
    assign w_exp_inc        = i_exp + 8'd1;
    assign o_ovf            = w_carry && (w_exp_inc == EXP_MAX);

    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    always_comb begin
        o_exp  = i_exp;
        o_mant = w_sum;
        if (w_carry) begin
            o_exp  = w_exp_inc;
            o_mant = '0;
        end
    end

endmodule

// File: rtl/fmul_round_pack.sv
// Two-stage round-and-pack pipeline for FP32 multiplier results with sticky flags.
// Define FMUL_ROUND_NEAREST_EN to round on the guard bit; default build truncates.
module fmul_round_pack
    import fpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    fmul_round_pack_if.slave    bus,
    input  logic                flag_clr,
    output logic [3:0]          flags,
    output logic [CNT_W-1:0]    result_cnt
);

    fp_unpacked_t w_in_op;
    fp_class_t    w_in_class;
    logic         w_in_inc;
    logic         w_s1_adv;
    logic         w_s2_adv;
    logic         w_out_fire;
    logic [3:0]   w_new_flags;

    logic         r_s1_valid;
    fp_class_t    r_s1_class;
    logic         r_s1_sign;
    logic         r_s1_ovf;
    logic [7:0]   r_s1_exp;
    logic [22:0]  r_s1_mant;
    logic         r_s1_inc;
    logic         r_s1_inexact;

    logic [7:0]   w_rnd_exp;
    logic [22:0]  w_rnd_mant;
    logic         w_rnd_ovf;
    logic [31:0]  w_pack_result;
    logic         w_pack_invalid;
    logic         w_pack_ovf;
    logic         w_pack_zero;

    logic         r_s2_valid;
    logic [31:0]  r_out_result;
    logic         r_out_invalid;
    logic         r_out_ovf;
    logic         r_out_inexact;
    logic         r_out_zero;

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_cnt;

    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_out_fire = r_s2_valid && bus.out_ready;

    assign w_in_op    = {bus.in_sign, bus.in_exp, bus.in_frac};
    assign w_in_class = classify(bus.in_error, bus.in_overflow, w_in_op.exp);

`ifdef FMUL_ROUND_NEAREST_EN
    assign w_in_inc = (w_in_class == FP_NORMAL) && w_in_op.frac[0];
`else
    assign w_in_inc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_class   <= FP_ZERO;
            r_s1_sign    <= 1'b0;
            r_s1_ovf     <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_mant    <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_class   <= w_in_class;
                r_s1_sign    <= w_in_op.sign;
                r_s1_ovf     <= bus.in_overflow;
                r_s1_exp     <= w_in_op.exp;
                r_s1_mant    <= w_in_op.frac[23:1];
                r_s1_inc     <= w_in_inc;
                r_s1_inexact <= (w_in_class == FP_NORMAL) && w_in_op.frac[0];
            end
        end
    end

    fp_round_inc u_round_inc (
        .i_exp  (r_s1_exp),
        .i_mant (r_s1_mant),
        .i_inc  (r_s1_inc),
        .o_exp  (w_rnd_exp),
        .o_mant (w_rnd_mant),
        .o_ovf  (w_rnd_ovf)
    );

    // Normal results take the rounded word; specials override it entirely.
    always_comb begin
        w_pack_result  = {r_s1_sign, w_rnd_exp, w_rnd_mant};
        w_pack_invalid = 1'b0;
        w_pack_ovf     = 1'b0;
        w_pack_zero    = 1'b0;
        case (r_s1_class)
            FP_NAN: begin
                w_pack_result  = {r_s1_sign, EXP_MAX, QNAN_MANT};
                w_pack_invalid = 1'b1;
            end
            FP_INF: begin
                if (r_s1_ovf) begin
                    w_pack_result = {r_s1_sign, EXP_MAX, 23'd0};
                    w_pack_ovf    = 1'b1;
                end else begin
                    w_pack_result = {r_s1_sign, EXP_MAX, r_s1_mant};
                end
            end
            FP_ZERO: begin
                w_pack_result = {r_s1_sign, 8'd0, 23'd0};
                w_pack_zero   = 1'b1;
            end
            default: begin
                w_pack_ovf = w_rnd_ovf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            r_out_result  <= '0;
            r_out_invalid <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_out_inexact <= 1'b0;
            r_out_zero    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result  <= w_pack_result;
                r_out_invalid <= w_pack_invalid;
                r_out_ovf     <= w_pack_ovf;
                r_out_inexact <= r_s1_inexact;
                r_out_zero    <= w_pack_zero;
            end
        end
    end

    assign w_new_flags = w_out_fire ? {r_out_zero, r_out_inexact, r_out_ovf, r_out_invalid} : 4'b0000;

    // A clear in the same cycle as a delivery keeps only the freshly delivered bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0000;
            r_cnt   <= '0;
        end else begin
            r_flags <= flag_clr ? w_new_flags : (r_flags | w_new_flags);
            if (w_out_fire && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready    = w_s1_adv;
    assign bus.out_valid   = r_s2_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_invalid = r_out_invalid;
    assign bus.out_ovf     = r_out_ovf;
    assign bus.out_inexact = r_out_inexact;
    assign flags           = r_flags;
    assign result_cnt      = r_cnt;

endmodule

// File: tb/tb_fmul_round_pack.sv
// Directed bench for fmul_round_pack: queue-based reference model checked every cycle,
// plus literal expectations for the key vectors. Honours FMUL_ROUND_NEAREST_EN.
module tb_fmul_round_pack;
    import fpu_pkg::*;

    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FMUL_ROUND_NEAREST_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        ovf;
        logic        inx;
        logic        zero;
    } expect_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flag_clr = 1'b0;
    logic [3:0]       flags;
    logic [CNT_W-1:0] result_cnt;

    expect_t    q[$];
    int         nVectors = 0;
    int         nFail = 0;
    int         nPushed = 0;
    logic [3:0] mFlags = 4'b0000;
    int         mCnt = 0;

    logic [7:0]  tExp  [6] = '{8'd1, 8'd254, 8'd128, 8'd255, 8'd0, 8'd77};
    logic [23:0] tFrac [6] = '{24'hFFFFFF, 24'h000000, 24'hABCDEF, 24'h000000, 24'h000001, 24'h7FFFFE};
    logic        tSign [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        tErr  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tOvf  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    fmul_round_pack_if bus();

    fmul_round_pack #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flag_clr   (flag_clr),
        .flags      (flags),
        .result_cnt (result_cnt)
    );

    always #5 clk = ~clk;

    // IEEE-754 packing done with integer arithmetic on the mantissa value.
    function automatic expect_t model(input logic s, input logic [7:0] e, input logic [23:0] f,
                                      input logic err, input logic ov);
        expect_t r;
        int m;
        int ex;
        r.res = 32'd0; r.inv = 1'b0; r.ovf = 1'b0; r.inx = 1'b0; r.zero = 1'b0;
        if (err) begin
            r.res = {s, 8'hff, 23'h400000};
            r.inv = 1'b1;
        end else if (ov) begin
            r.res = {s, 8'hff, 23'd0};
            r.ovf = 1'b1;
        end else if (e == 8'hff) begin
            r.res = {s, 8'hff, f[23:1]};
        end else if (e == 8'd0) begin
            r.res  = {s, 31'd0};
            r.zero = 1'b1;
        end else begin
            r.inx = f[0];
            m  = int'(f[23:1]) + ((ROUND_EN && f[0]) ? 1 : 0);
            ex = int'(e);
            if (m >= (1 << 23)) begin
                m  = m - (1 << 23);
                ex = ex + 1;
            end
            if (ex >= 255) begin
                r.res = {s, 8'hff, 23'd0};
                r.ovf = 1'b1;
            end else begin
                r.res = {s, 8'(ex), 23'(m)};
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nVectors++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        expect_t    e;
        logic [3:0] newBits;
        newBits = 4'b0000;
        if (rst) begin
            q.delete();
            mFlags = 4'b0000;
            mCnt   = 0;
        end else begin
            check("flags", 32'(flags), 32'(mFlags));
            check("result_cnt", 32'(result_cnt), 32'(mCnt));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("out_valid with nothing outstanding", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = q[0];
                    check("out_result", bus.out_result, e.res);
                    check("out_invalid", 32'(bus.out_invalid), 32'(e.inv));
                    check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                    check("out_inexact", 32'(bus.out_inexact), 32'(e.inx));
                    if (bus.out_ready) begin
                        q.delete(0);
                        newBits = {e.zero, e.inx, e.ovf, e.inv};
                        if (mCnt < CNT_MAX)
                            mCnt++;
                    end
                end
            end
            mFlags = flag_clr ? newBits : (mFlags | newBits);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_sign, bus.in_exp, bus.in_frac, bus.in_error, bus.in_overflow));
                nPushed++;
            end
        end
    end

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_result", bus.out_result, 32'd0);
        check("reset out bits", 32'({bus.out_invalid, bus.out_ovf, bus.out_inexact}), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset result_cnt", 32'(result_cnt), 32'd0);
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [23:0] f,
                                 input logic err, input logic ov);
        bit accepted;
        accepted        = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_sign     = s;
        bus.in_exp      = e;
        bus.in_frac     = f;
        bus.in_error    = err;
        bus.in_overflow = ov;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready)
                accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        check("input accepted in time", 32'(accepted), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] res, input logic [2:0] bits,
                               input logic [3:0] fl);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid)
                seen = 1'b1;
        end
        check({name, " out_valid seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " result"}, bus.out_result, res);
            check({name, " inv/ovf/inx"}, 32'({bus.out_invalid, bus.out_ovf, bus.out_inexact}), 32'(bits));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, " flags"}, 32'(flags), 32'(fl));
        @(posedge clk);
        #1;
    endtask

    task automatic clearFlags();
        flag_clr = 1'b1;
        @(posedge clk);
        #1 flag_clr = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 30 && (q.size() != 0 || bus.out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check({name, " drained"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int startPushed;
        bus.in_valid    = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_exp      = 8'd0;
        bus.in_frac     = 24'd0;
        bus.in_error    = 1'b0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b1;
        @(posedge clk);
        #1;
        doReset();

        applyStimulus(1'b0, 8'(EXP_BIAS), 24'h800000, 1'b0, 1'b0);
        checkOutput("basic", 32'h3FC00000, 3'b000, 4'b0000);

        applyStimulus(1'b0, 8'd127, 24'hFFFFFF, 1'b0, 1'b0);
        if (ROUND_EN)
            checkOutput("round carry", 32'h40000000, 3'b001, 4'b0100);
        else
            checkOutput("round carry", 32'h3FFFFFFF, 3'b001, 4'b0100);
        clearFlags();

        applyStimulus(1'b0, 8'd254, 24'hFFFFFF, 1'b0, 1'b0);
        if (ROUND_EN)
            checkOutput("round overflow", 32'h7F800000, 3'b011, 4'b0110);
        else
            checkOutput("round overflow", 32'h7F7FFFFF, 3'b001, 4'b0100);
        clearFlags();

        applyStimulus(1'b0, 8'hff, 24'h800000, 1'b1, 1'b0);
        checkOutput("nan", 32'h7FC00000, 3'b100, 4'b0001);
        clearFlags();

        applyStimulus(1'b1, 8'd0, 24'h000000, 1'b0, 1'b0);
        checkOutput("zero", 32'h80000000, 3'b000, 4'b1000);
        clearFlags();

        applyStimulus(1'b1, 8'd200, 24'h123456, 1'b0, 1'b1);
        checkOutput("overflow in", 32'hFF800000, 3'b010, 4'b0010);
        clearFlags();

        applyStimulus(1'b0, 8'hff, 24'h000002, 1'b0, 1'b0);
        checkOutput("inf passthrough", 32'h7F800001, 3'b000, 4'b0000);

        applyStimulus(1'b1, 8'd0, 24'h000000, 1'b1, 1'b1);
        checkOutput("error priority", 32'hFFC00000, 3'b100, 4'b0001);
        clearFlags();

        // Backpressure: only two results fit while the output is stalled.
        doReset();
        bus.out_ready = 1'b0;
        startPushed = nPushed;
        fork
            begin
                applyStimulus(1'b0, 8'd100, 24'h100000, 1'b0, 1'b0);
                applyStimulus(1'b1, 8'd101, 24'h200001, 1'b0, 1'b0);
                applyStimulus(1'b0, 8'd102, 24'h300000, 1'b0, 1'b0);
                applyStimulus(1'b1, 8'd0, 24'h000000, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stall accepted count", 32'(nPushed - startPushed), 32'd2);
                check("stall in_ready", 32'(bus.in_ready), 32'd0);
                check("stall out_valid", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b1;
            end
        join
        waitDrain("backpressure");
        check("backpressure result_cnt", 32'(result_cnt), 32'd4);

        for (int i = 0; i < 6; i++)
            applyStimulus(tSign[i], tExp[i], tFrac[i], tErr[i], tOvf[i]);
        waitDrain("table");
        check("saturated result_cnt", 32'(result_cnt), 32'(CNT_MAX));

        applyStimulus(1'b0, 8'd130, 24'h000001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("clear race out_valid", 32'(bus.out_valid), 32'd1);
        flag_clr = 1'b1;
        @(posedge clk);
        #1 flag_clr = 1'b0;
        check("clear race flags", 32'(flags), 32'b0100);

        applyStimulus(1'b0, 8'd131, 24'h000001, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd132, 24'h000003, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midflight reset out_valid", 32'(bus.out_valid), 32'd0);
        check("midflight reset flags", 32'(flags), 32'd0);
        check("midflight reset result_cnt", 32'(result_cnt), 32'd0);
        check("midflight reset in_ready", 32'(bus.in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("discarded results stay gone", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fmul_round_pack.md
Name: fmul_round_pack

Overview:
- Downstream neighbour of the FP32 multiplier core. Consumes its unpacked result (sign, exp, 24-bit frac with guard bit, error, overflow), rounds, and packs to an IEEE-754 single-precision word.
- Two-stage pipeline with valid/ready backpressure. Produces per-result exception bits and a sticky status register for the FPU front end.

Parameters:
- CNT_W, 16, width of the saturating completed-result counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage 1 can accept this cycle.
- in_sign  in  1  result sign.
- in_exp  in  8  biased exponent; 0 means zero/underflow, 8'hff means inf/NaN.
- in_frac  in  24  [23:1] is the 23-bit mantissa; [0] is the guard bit.
- in_error  in  1  invalid operation (NaN result).
- in_overflow  in  1  exponent overflow.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  {sign, exp, mantissa}.
- out_invalid  out  1  per-result invalid.
- out_ovf  out  1  per-result overflow, including overflow caused by rounding.
- out_inexact  out  1  per-result inexact.
- flag_clr  in  1  clears the sticky flags.
- flags  out  4  sticky flags: [0] invalid, [1] overflow, [2] inexact, [3] zero result.
- result_cnt  out  CNT_W  number of results accepted by downstream; saturating.

Behaviour:
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, all out_* bits=0, flags=0, result_cnt=0.
- Pipeline:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational; no combinational path from in_valid).
  - Stage 1 captures the inputs on in_valid & in_ready.
  - Stage 2 captures stage 1 when s1_valid & s2_adv.
  - Latency is 2 cycles from acceptance to out_valid with no stall. Throughput is 1 result per cycle.
  - Outputs hold stable while out_valid & !out_ready.
  - No drops, no duplicates, in-order.
- Stage 1 classification (priority order):
  - in_error → special NaN.
  - in_overflow or in_exp==8'hff → special inf/NaN pass-through.
  - in_exp==0 → zero.
  - otherwise → normal.
  - Stage 1 also computes the round increment (see Optional Feature) and inexact = normal & in_frac[0].
- Stage 2 packing:
  - NaN → {in_sign, 8'hff, 23'h400000}; out_invalid=1.
  - Overflow → {sign, 8'hff, 0}; out_ovf=1.
  - Exp 8'hff without error → {sign, 8'hff, frac[23:1]}.
  - Zero → {sign, 8'h00, 0}; flags[3] is set.
  - Normal → {sign, exp', mant'}, where {carry, mant'} = frac[23:1] + inc (24-bit add).
    - carry=1 → mant'=0, exp'=exp+1.
    - exp+1 == 255 → result is {sign, 8'hff, 0} with out_ovf=1 and inexact=1.
- Sticky flags:
  - Each bit is ORed from the result on the out_valid & out_ready handshake.
  - flag_clr clears all bits. When flag_clr and a set occur in the same cycle, the set wins for the newly set bits.
- result_cnt: increments on each out_valid & out_ready handshake and saturates at all-ones.
- Reset mid-operation: in-flight results are discarded, and in_ready=1 in the cycle after rst deasserts.

Optional Feature:
- Macro: FMUL_ROUND_NEAREST_EN.
- Defined: inc = in_frac[0] for normal results (round half away from zero on the guard bit; no sticky bit exists).
- Undefined: inc = 0 (truncation). out_inexact and flags[2] still report in_frac[0].

Decomposition:
- Package fpu_pkg holds:
  - EXP_MAX=8'hff and EXP_BIAS=127.
  - QNAN_MANT=23'h400000.
  - An enum fp_class_t {FP_NORMAL, FP_ZERO, FP_INF, FP_NAN}.
  - A struct fp_unpacked_t {sign, exp, frac[23:0]}.
- One sub-module, fp_round_inc: combinational mantissa increment with carry and exponent bump/overflow detection, instantiated in stage 2.

Test Plan:
- Basic pack: sign=0, exp=127, frac=24'h800000, out_ready=1 → out_result=32'h3FC00000 two cycles later; no flags set.
- Round carry: exp=127, frac=24'hFFFFFF.
  - With the macro → 32'h40000000, out_inexact=1.
  - Without the macro → 32'h3FFFFFFF, flags[2]=1.
- Round into overflow: exp=254, frac=24'hFFFFFF, macro on → 32'h7F800000, out_ovf=1, flags=4'b0110.
- Specials:
  - in_error=1, exp=8'hff, frac=24'h800000 → 32'h7FC00000, flags[0]=1.
  - exp=0, sign=1 → 32'h80000000, flags[3]=1.
- Backpressure: issue 4 back-to-back inputs with out_ready=0 → in_ready drops after 2 are accepted. Then set out_ready=1 → all 4 emerge in order, and result_cnt=4.
- Flag clear race and reset: flag_clr=1 in the handshake cycle of an inexact result → flags=4'b0100. Then assert rst with 2 results in flight → out_valid=0, flags=0, result_cnt=0 next cycle.
